// File: rtl/gpr_file_sb.sv
// Parametrised GPR file: two write ports, NREAD combinational read ports,
// optional write-to-read bypass and a per-register busy scoreboard with a registered count.
module gpr_file_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREAD*ADDR_W-1:0]  rd_addr,
  output logic [NREAD*DATA_W-1:0]  rd_data,
  output logic [NREAD-1:0]         rd_busy,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic                     clr1,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_rd,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int unsigned     DEPTH   = 2**ADDR_W;
  localparam bit              ZR      = (ZERO_REG != 0);
  localparam bit              BP      = (BYPASS != 0);
  localparam logic [ADDR_W:0] CNT_ONE = 1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              w0_ok, w1_ok, set_ok, clr_ok;
  logic              net_set, net_clr;

  assign w0_ok  = we0 && !(ZR && (wa0 == '0));
  assign w1_ok  = we1 && !(ZR && (wa1 == '0));
  assign set_ok = iss_valid && !(ZR && (iss_rd == '0));
  assign clr_ok = w1_ok && clr1;

  // Set beats clear on the same register, so a clear only counts when no issue targets it.
  assign net_set = set_ok && !busy[iss_rd];
  assign net_clr = clr_ok && busy[wa1] && !(set_ok && (iss_rd == wa1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (w0_ok) regs[wa0] <= wd0;
      if (w1_ok) regs[wa1] <= wd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (clr_ok) busy[wa1]    <= 1'b0;
      if (set_ok) busy[iss_rd] <= 1'b1;
      if (net_set && !net_clr)      busy_cnt <= busy_cnt + CNT_ONE;
      else if (net_clr && !net_set) busy_cnt <= busy_cnt - CNT_ONE;
    end
  end

  genvar g;
  for (g = 0; g < NREAD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              is_zero, hit0, hit1, clr_hit;

    assign ra      = rd_addr[g*ADDR_W +: ADDR_W];
    assign is_zero = ZR && (ra == '0);
    assign hit1    = BP && w1_ok && (wa1 == ra);
    assign hit0    = BP && w0_ok && (wa0 == ra);
    assign clr_hit = BP && clr_ok && (wa1 == ra) && !(set_ok && (iss_rd == ra));

    always_comb begin
      if (is_zero)   rd_data[g*DATA_W +: DATA_W] = '0;
      else if (hit1) rd_data[g*DATA_W +: DATA_W] = wd1;
      else if (hit0) rd_data[g*DATA_W +: DATA_W] = wd0;
      else           rd_data[g*DATA_W +: DATA_W] = regs[ra];
    end

    assign rd_busy[g] = !is_zero && !clr_hit && busy[ra];
  end

endmodule

// File: doc/gpr_file_sb.md
Name: gpr_file_sb

Overview:
Parametrised general-purpose register file for the pipelined CPU, the successor of the fixed 32x32 two-read, one-write file.
- Configurable data width, depth and read-port count.
- Two write ports: port 0 for the EX/MEM early result, port 1 for WB.
- Optional same-cycle write-to-read bypass.
- Per-register busy scoreboard, set at issue and cleared at writeback, used by the hazard unit for stall decisions.
- Sits between ID (read/issue) and WB (write) stages.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
NREAD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy
BYPASS, 1, 1 = same-cycle write data/clear forwarded to read ports

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; clears storage and scoreboard
rd_addr  in  NREAD*ADDR_W  read addresses; port i = bits [i*ADDR_W +: ADDR_W]
rd_data  out  NREAD*DATA_W  read data, combinational; port i = [i*DATA_W +: DATA_W]
rd_busy  out  NREAD  scoreboard busy flag per read port, combinational
we0  in  1  write enable, port 0
wa0  in  ADDR_W  write address, port 0
wd0  in  DATA_W  write data, port 0
we1  in  1  write enable, port 1
wa1  in  ADDR_W  write address, port 1
wd1  in  DATA_W  write data, port 1
clr1  in  1  port 1 write also clears the busy bit of wa1 (final writeback)
iss_valid  in  1  instruction issued with a destination
iss_rd  in  ADDR_W  destination register of the issued instruction
busy_cnt  out  ADDR_W+1  registered count of busy registers

Behaviour:
- Reset (async, active-high):
  - All registers go to 0, all busy bits to 0, busy_cnt = 0 immediately, independent of clock.
  - Reset asserted mid-write discards the write.
  - First write is accepted on the first rising edge after reset deasserts.
- Writes, on posedge clock:
  - we0 writes wd0 to wa0; we1 writes wd1 to wa1.
  - Both enabled to the same address: port 1 wins (newer in program order is WB... port 1 data is final).
  - ZERO_REG=1 with wa=0: write ignored.
- Reads, combinational, zero latency:
  - rd_data = storage[addr].
  - ZERO_REG=1 and addr=0: rd_data = 0, rd_busy = 0.
- Bypass (BYPASS=1), per read port:
  - Matching address with we1 this cycle returns wd1.
  - Else a matching address with we0 returns wd0.
  - Else storage.
  - Address 0 is never bypassed when ZERO_REG=1.
  - BYPASS=0: reads return storage only; new data is visible the cycle after the write.
- Scoreboard, updated at posedge:
  - iss_valid sets busy[iss_rd].
  - we1 & clr1 clears busy[wa1].
  - Set and clear to the same register in the same cycle: set wins (new producer in flight), busy stays 1.
  - iss_rd=0 with ZERO_REG=1: no set.
  - Setting an already-busy register or clearing an idle one leaves the bit unchanged; no error.
- rd_busy:
  - rd_busy = busy[addr].
  - BYPASS=1 only: forced to 0 when this cycle's we1&clr1 targets the same address and no same-cycle issue targets it.
- busy_cnt:
  - Equals the popcount of the busy vector after each edge: +1 on a net set, -1 on a net clear, unchanged otherwise.
  - Maximum value is 2**ADDR_W - ZERO_REG; no overflow is possible.
- No X on any output after reset; unused high rd_addr bits are not permitted (NREAD fixes the width).

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, then pulse reset mid-cycle -> rd_data(r5) = 0 immediately, busy_cnt = 0.
- Zero register: we1, wa1=0, wd1=0x1234, then iss_rd=0 -> rd_data(r0) = 0, rd_busy = 0, busy_cnt = 0.
- Dual-write collision: we0/we1 both to r7 with wd0=0x11, wd1=0x22 -> bypass read gives 0x22 same cycle; storage holds 0x22 next cycle.
- Bypass on/off: write 0xA5A5A5A5 to r3 while reading r3:
  - BYPASS=1 -> 0xA5A5A5A5 same cycle.
  - BYPASS=0 -> old value same cycle, 0xA5A5A5A5 next cycle.
- Scoreboard:
  - Issue r9 -> busy next cycle, busy_cnt = 1.
  - we1/clr1 to r9 -> rd_busy = 0 same cycle (BYPASS=1); busy_cnt = 0 next cycle.
- Set/clear race: r4 busy, then iss_rd=4 together with we1/clr1 to r4 -> busy stays 1, busy_cnt unchanged at 1, rd_data(r4) = new wd1.
